// File: rtl/msm_run_ctrl.sv
// Run controller for the msm_arr ap_ctrl_hs kernel: one invocation per window, plus memory-select ownership.
// Start at cmd+2, 3 cycles of overhead per window; one command at a time, resp held until resp_ready.
module msm_run_ctrl #(
    parameter int WIN_W = 5,
    parameter int TO_W  = 24
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIN_W-1:0] cmd_num_win,
    input  logic [TO_W-1:0]  timeout_cycles,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_status,
    output logic [WIN_W-1:0] resp_win_done,
    output logic             k_ap_start,
    input  logic             k_ap_done,
    input  logic             k_ap_idle,
    input  logic             k_ap_ready,
    output logic [WIN_W-1:0] win_idx,
    output logic             mem_owner,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_START,
        S_RUN,
        S_NEXT,
        S_DRAIN,
        S_RESP
    } state_t;

    localparam logic [1:0]       ST_OK      = 2'b00;
    localparam logic [1:0]       ST_TIMEOUT = 2'b01;
    localparam logic [TO_W-1:0]  TO_ONE     = TO_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);

    state_t           state_q;
    logic [WIN_W-1:0] num_win_q;
    logic [WIN_W-1:0] win_idx_q;
    logic [WIN_W-1:0] win_done_q;
    logic [WIN_W-1:0] win_done_d;
    logic [TO_W-1:0]  to_lim_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TO_W-1:0]  to_cnt_d;
    logic [1:0]       status_q;
    logic             mem_owner_q;
    logic             to_hit;

    // Both counters saturate rather than wrap.
    assign to_cnt_d   = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TO_ONE;
    assign win_done_d = (&win_done_q) ? win_done_q : win_done_q + WIN_ONE;
    assign to_hit     = (to_lim_q != '0) && (to_cnt_q == to_lim_q - TO_ONE);

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign k_ap_start    = (state_q == S_START);
    assign resp_valid    = (state_q == S_RESP);
    assign resp_status   = status_q;
    assign resp_win_done = win_done_q;
    assign win_idx       = win_idx_q;
    assign mem_owner     = mem_owner_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= S_IDLE;
            num_win_q   <= '0;
            win_idx_q   <= '0;
            win_done_q  <= '0;
            to_lim_q    <= '0;
            to_cnt_q    <= '0;
            status_q    <= ST_OK;
            mem_owner_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        num_win_q  <= cmd_num_win;
                        to_lim_q   <= timeout_cycles;
                        win_idx_q  <= '0;
                        win_done_q <= '0;
                        status_q   <= ST_OK;
                        if (cmd_num_win == '0) begin
                            state_q <= S_RESP;
                        end else begin
                            mem_owner_q <= 1'b1;
                            state_q     <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (k_ap_idle) begin
                        to_cnt_q <= '0;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    // Done only counts once ready is seen; a completion beats a same-cycle timeout.
                    to_cnt_q <= to_cnt_d;
                    if (k_ap_ready && k_ap_done) begin
                        state_q <= S_NEXT;
                    end else if (to_hit) begin
                        status_q <= ST_TIMEOUT;
                        state_q  <= S_DRAIN;
                    end else if (k_ap_ready) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    to_cnt_q <= to_cnt_d;
                    if (k_ap_done) begin
                        state_q <= S_NEXT;
                    end else if (to_hit) begin
                        status_q <= ST_TIMEOUT;
                        state_q  <= S_DRAIN;
                    end
                end
                S_NEXT: begin
                    win_done_q <= win_done_d;
                    if (win_done_d == num_win_q) begin
                        mem_owner_q <= 1'b0;
                        state_q     <= S_RESP;
                    end else begin
                        win_idx_q <= win_idx_q + WIN_ONE;
                        state_q   <= S_WAIT_IDLE;
                    end
                end
                S_DRAIN: begin
                    // Memories stay with the kernel until it is idle again.
                    if (k_ap_idle) begin
                        mem_owner_q <= 1'b0;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msm_run_ctrl.sv
// Bench for msm_run_ctrl: behavioural ap_ctrl_hs kernel, table vectors, latency-arithmetic model for random runs.
module tb_msm_run_ctrl;

    localparam int WIN_W = 5;
    localparam int TO_W  = 24;

    logic             ap_clk;
    logic             ap_rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIN_W-1:0] cmd_num_win;
    logic [TO_W-1:0]  timeout_cycles;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_status;
    logic [WIN_W-1:0] resp_win_done;
    logic             k_ap_start;
    logic             k_ap_done;
    logic             k_ap_idle;
    logic             k_ap_ready;
    logic [WIN_W-1:0] win_idx;
    logic             mem_owner;
    logic             busy;

    msm_run_ctrl #(.WIN_W(WIN_W), .TO_W(TO_W)) dut (
        .ap_clk         (ap_clk),
        .ap_rst_n       (ap_rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_num_win    (cmd_num_win),
        .timeout_cycles (timeout_cycles),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_status    (resp_status),
        .resp_win_done  (resp_win_done),
        .k_ap_start     (k_ap_start),
        .k_ap_done      (k_ap_done),
        .k_ap_idle      (k_ap_idle),
        .k_ap_ready     (k_ap_ready),
        .win_idx        (win_idx),
        .mem_owner      (mem_owner),
        .busy           (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int num;
        int to;
        int rdy;
        int dn;
        int hw;
        int hl;
        int hold;
        bit pulse;
        int est;
        int ewd;
        int elat;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Kernel model knobs: ready/done offsets from the first start cycle, hung window index and hang length.
    int k_rdy = 1;
    int k_dn  = 4;
    int k_hw  = -1;
    int k_hl  = 0;
    bit k_clr = 1'b0;
    bit kact  = 1'b0;
    bit kend  = 1'b0;
    bit khang = 1'b0;
    int kt    = 0;
    int kinv  = 0;

    int r_st, r_wd, r_lat, r_nst, r_first, r_idx_err, r_own_err, r_stab_err, r_idle_ok;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin : kernel
        k_ap_idle  = 1'b1;
        k_ap_ready = 1'b0;
        k_ap_done  = 1'b0;
        forever begin
            @(posedge ap_clk);
            #2;
            if (k_clr) begin
                kact = 1'b0;
                kend = 1'b0;
                kinv = 0;
            end
            if (kend) begin
                kact = 1'b0;
                kend = 1'b0;
            end
            if (!kact && k_ap_start) begin
                kact  = 1'b1;
                kt    = 0;
                khang = (kinv == k_hw);
                kinv++;
            end else if (kact) begin
                kt++;
            end
            if (kact && khang && kt >= k_hl) kact = 1'b0;
            k_ap_ready = kact && (kt == k_rdy);
            k_ap_done  = kact && !khang && (kt == k_dn);
            k_ap_idle  = !kact;
            if (k_ap_done) kend = 1'b1;
        end
    end

    // Expected outcome from window latencies: each window starts dn+3 cycles after the previous one.
    function automatic vec_t model(input vec_t vi);
        vec_t v = vi;
        int s = 2;
        int idle_at;
        v.est  = 0;
        v.ewd  = vi.num;
        v.elat = 1;
        if (vi.num == 0) begin
            v.ewd = 0;
            return v;
        end
        for (int w = 0; w < vi.num; w++) begin
            bit hung = (w == vi.hw);
            if (vi.to != 0 && (hung || vi.dn > vi.to - 1)) begin
                idle_at = hung ? s + vi.hl : s + vi.dn + 1;
                v.est  = 1;
                v.ewd  = w;
                v.elat = ((s + vi.to > idle_at) ? s + vi.to : idle_at) + 1;
                return v;
            end
            if (w == vi.num - 1) begin
                v.elat = s + vi.dn + 2;
                return v;
            end
            s += vi.dn + 3;
        end
        return v;
    endfunction

    task automatic run_cmd(input vec_t v);
        int c;
        logic prev;
        k_rdy = v.rdy;
        k_dn  = v.dn;
        k_hw  = v.hw;
        k_hl  = v.hl;
        k_clr = 1'b1;
        tick();
        k_clr = 1'b0;
        check("cmd_ready_before", cmd_ready, 1);
        cmd_num_win    = v.num[WIN_W-1:0];
        timeout_cycles = v.to[TO_W-1:0];
        cmd_valid      = 1'b1;
        resp_ready     = (v.hold == 0);
        tick();
        cmd_valid = 1'b0;
        if (v.pulse) cmd_num_win = 5'd7;
        c = 1; prev = 1'b0;
        r_nst = 0; r_first = -1; r_idx_err = 0; r_own_err = 0; r_stab_err = 0;
        r_lat = -1; r_st = -1; r_wd = -1;
        while (r_lat < 0 && c < 2000) begin
            cmd_valid = v.pulse && c >= 3 && c < 6;
            if (k_ap_start && !prev) begin
                if (win_idx !== r_nst[WIN_W-1:0]) r_idx_err++;
                if (r_first < 0) r_first = c;
                r_nst++;
            end
            prev = k_ap_start;
            if (resp_valid === 1'b1) begin
                r_lat = c;
                r_st  = int'(resp_status);
                r_wd  = int'(resp_win_done);
                if (mem_owner !== 1'b0) r_own_err++;
            end else begin
                if (mem_owner !== (v.num != 0)) r_own_err++;
                tick();
                c++;
            end
        end
        cmd_valid = 1'b0;
        if (r_lat < 0) check("resp_arrived", resp_valid, 1);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_status !== r_st[1:0] || resp_win_done !== r_wd[WIN_W-1:0])
                r_stab_err++;
        end
        resp_ready = 1'b1;
        tick();
        r_idle_ok = (cmd_ready === 1'b1 && resp_valid === 1'b0 && k_ap_start === 1'b0) ? 1 : 0;
        tick();
        tick();
        if (busy !== 1'b0) r_idle_ok = 0;
    endtask

    task automatic do_vec(input string name, input vec_t v);
        int exp_nst;
        exp_nst = (v.est != 0) ? v.ewd + 1 : v.num;
        run_cmd(v);
        check({name, "_status"},   r_st, v.est);
        check({name, "_win_done"}, r_wd, v.ewd);
        check({name, "_resp_lat"}, r_lat, v.elat);
        check({name, "_starts"},   r_nst, exp_nst);
        check({name, "_win_idx"},  r_idx_err, 0);
        check({name, "_mem_own"},  r_own_err, 0);
        check({name, "_stable"},   r_stab_err, 0);
        check({name, "_idle"},     r_idle_ok, 1);
        if (exp_nst > 0) check({name, "_first_start"}, r_first, 2);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_cmd_ready"},  cmd_ready, 1);
        check({name, "_busy"},       busy, 0);
        check({name, "_k_start"},    k_ap_start, 0);
        check({name, "_mem_owner"},  mem_owner, 0);
        check({name, "_win_idx"},    win_idx, 0);
        check({name, "_resp_valid"}, resp_valid, 0);
        check({name, "_resp_st"},    resp_status, 0);
        check({name, "_resp_wd"},    resp_win_done, 0);
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[10];

    initial begin : main
        vec_t v;
        int n, c;
        logic prev;

        tbl[0] = '{1, 0, 1, 4, -1, 0, 0, 1'b0, 0, 1, 8};
        tbl[1] = '{3, 0, 1, 10, -1, 0, 0, 1'b0, 0, 3, 40};
        tbl[2] = '{0, 0, 1, 4, -1, 0, 0, 1'b0, 0, 0, 1};
        tbl[3] = '{2, 0, 1, 1, -1, 0, 0, 1'b0, 0, 2, 9};
        tbl[4] = '{2, 5, 1, 4, -1, 0, 0, 1'b0, 0, 2, 15};
        tbl[5] = '{2, 4, 1, 4, -1, 0, 0, 1'b0, 1, 0, 8};
        tbl[6] = '{3, 50, 1, 10, 1, 200, 0, 1'b0, 1, 1, 216};
        tbl[7] = '{1, 1, 1, 3, -1, 0, 0, 1'b0, 1, 0, 7};
        tbl[8] = '{4, 20, 2, 2, -1, 0, 0, 1'b0, 0, 4, 21};
        tbl[9] = '{2, 0, 1, 3, -1, 0, 10, 1'b1, 0, 2, 13};

        ap_rst_n       = 1'b0;
        cmd_valid      = 1'b0;
        cmd_num_win    = '0;
        timeout_cycles = '0;
        resp_ready     = 1'b1;
        repeat (3) tick();
        check_reset_outputs("por");
        ap_rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) do_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset while window 1 of 3 is running.
        k_rdy = 1; k_dn = 10; k_hw = -1; k_hl = 0;
        k_clr = 1'b1;
        tick();
        k_clr = 1'b0;
        cmd_num_win = 5'd3; timeout_cycles = '0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0; c = 0; prev = 1'b0;
        while (n < 2 && c < 500) begin
            if (k_ap_start && !prev) n++;
            prev = k_ap_start;
            if (n < 2) begin
                tick();
                c++;
            end
        end
        check("rst_reach_win1", n, 2);
        repeat (3) tick();
        check("rst_pre_owner", mem_owner, 1);
        check("rst_pre_idx", win_idx, 1);
        check("rst_pre_busy", busy, 1);
        #3 ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        k_clr = 1'b1;
        tick();
        tick();
        k_clr = 1'b0;
        ap_rst_n = 1'b1;
        tick();
        check("rst_rel_cmd_ready", cmd_ready, 1);
        check("rst_rel_k_start", k_ap_start, 0);

        for (int i = 0; i < 40; i++) begin
            v.num   = $urandom_range(0, 5);
            v.rdy   = $urandom_range(1, 3);
            v.dn    = v.rdy + $urandom_range(0, 8);
            v.to    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 14);
            v.hw    = (v.to != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
            v.hl    = $urandom_range(5, 40);
            v.hold  = $urandom_range(0, 3);
            v.pulse = ($urandom_range(0, 1) == 1);
            v = model(v);
            do_vec($sformatf("rnd%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msm_run_ctrl.md
# msm_run_ctrl

Run controller for the `msm_arr` HLS kernel (ap_ctrl_hs).
- Accepts a command to process N scalar windows and invokes the kernel once per window, driving the window index argument.
- Performs the `ap_start`/`ap_ready`/`ap_done` handshake for each invocation.
- Owns the select that hands the P_arr/K_arr/B_i memories to the kernel while a run is active and back to the loader afterwards.
- Sits between the host command path and `msm_arr`/`test_case_mem`.

## Interface
- `WIN_W`, 5: width of window count/index.
- `TO_W`, 24: width of the timeout counter.
- `ap_clk`  in  1  clock, all logic on rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  run request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_num_win`  in  WIN_W  number of kernel invocations, 0 allowed.
- `timeout_cycles`  in  TO_W  per-invocation limit, sampled with command; 0 disables.
- `resp_valid`  out  1  run finished.
- `resp_ready`  in  1  response accepted.
- `resp_status`  out  2  00 ok, 01 timeout.
- `resp_win_done`  out  WIN_W  invocations completed with ap_done.
- `k_ap_start`  out  1  to kernel `ap_start`.
- `k_ap_done`, `k_ap_idle`, `k_ap_ready`  in  1 each  from kernel.
- `win_idx`  out  WIN_W  current window argument to kernel.
- `mem_owner`  out  1  0 = loader owns memories, 1 = kernel owns.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, WAIT_IDLE, START, RUN, NEXT, DRAIN, RESP.
- IDLE: `cmd_ready`=1. Handshake (`cmd_valid`&`cmd_ready`) latches `num_win` and `to_lim`, and clears `win_idx` and `win_done`.
  - `num_win`==0: go to RESP, status 00, win_done 0, `mem_owner` stays 0.
  - Otherwise: set `mem_owner`<=1 and go to WAIT_IDLE.
- WAIT_IDLE: stay until `k_ap_idle`=1, then go to START and clear the timeout counter.
- START: `k_ap_start`=1, held until `k_ap_ready` is sampled high.
  - Ready and done in the same cycle: go to NEXT.
  - Ready only: go to RUN.
- RUN: `k_ap_start`=0. Wait for `k_ap_done`, then go to NEXT. A `k_ap_done` arriving while still in START (before ready) is ignored; the kernel cannot signal done before ready.
- NEXT (one cycle): `win_done`++.
  - If the new `win_done`==`num_win`: set `mem_owner`<=0 and go to RESP, status 00.
  - Otherwise: `win_idx`++ and go to WAIT_IDLE.
- Timeout: the counter increments every cycle in START/RUN. When `to_lim`!=0 and the counter == `to_lim`-1 with no done that cycle:
  - deassert `k_ap_start`, latch status 01, go to DRAIN.
  - done and timeout in the same cycle: done wins.
- DRAIN: hold `mem_owner`=1 until `k_ap_idle`=1, then set `mem_owner`<=0 and go to RESP. The kernel never loses its memories while active.
- RESP: `resp_valid`=1; `resp_status`/`resp_win_done` are stable. On `resp_ready`, go to IDLE.
- `cmd_valid` outside IDLE is not accepted and is not queued.
- Width rules:
  - `win_idx` == `win_done` at every START entry.
  - `win_done` counts up to 2^WIN_W-1 with no wrap.
  - The timeout counter saturates.

## Timing
- Reset (async assert, sync deassert):
  - state IDLE, `cmd_ready`=1, `busy`=0.
  - `k_ap_start`=0, `mem_owner`=0, `win_idx`=0.
  - `resp_valid`=0, `resp_status`=00, `resp_win_done`=0.
- Reset mid-run forces all of the above immediately. The kernel's own reset is the integrator's responsibility.
- All outputs are registered or decoded directly from the state register; no combinational path from kernel inputs to outputs.
- Latency from command handshake at cycle 0 with kernel idle: `mem_owner`=1 and WAIT_IDLE at 1; `k_ap_start`=1 at 2.
- After `k_ap_done` at cycle d:
  - NEXT at d+1.
  - Next `k_ap_start` at d+3 if the kernel is idle.
  - Or `resp_valid` at d+2 on the last window.
- Per-window overhead: 3 cycles plus kernel latency.

## Test plan
- Reset mid-RUN (window 1 of 3):
  - Required: all outputs at reset values the same cycle `ap_rst_n` falls.
  - After release: `cmd_ready`=1 and `k_ap_start`=0.
- `cmd_num_win`=3, kernel model with ready at start+1 and done at start+10:
  - Required: three `k_ap_start` pulses with `win_idx`=0,1,2.
  - `mem_owner`=1 from cycle 1 until the cycle after the third NEXT.
  - Response status 00, win_done 3.
- `cmd_num_win`=0:
  - Required: `resp_valid` at cycle 1, win_done 0, `k_ap_start` never asserted, `mem_owner` never 1.
- Kernel asserts ready and done in the same cycle, `num_win`=2:
  - Required: direct START→NEXT, `win_idx` advances to 1, status 00, win_done 2.
- `timeout_cycles`=50, kernel hangs on window 1 with idle=0 for 200 cycles, then idle=1:
  - Required: `k_ap_start` drops at the timeout and `mem_owner` stays 1 through DRAIN.
  - `resp_valid` arrives 1 cycle after idle, status 01, win_done 1.
- Response backpressure (`resp_ready`=0 for 10 cycles) plus `cmd_valid` pulsed during the run:
  - Required: `resp_*` stable throughout, the second command is not accepted, and IDLE is reached the cycle after `resp_ready`.
